liteic_slave_node_rd_arb: RTL and testbench
===========================================

LITEIC_SLAVE_NODE_RD_ARB -- requirements
Module: liteic_slave_node_rd_arb

Interface
REQ-001 SHALL have parameter NUM_MST, default IC_NUM_MASTER_SLOTS, crossbar master-slot count.
REQ-002 SHALL have parameter ADDR_W, default IC_ARADDR_WIDTH, AR address width.
REQ-003 SHALL have parameter RDATA_W, default IC_RDATA_WIDTH, packed {r_data, r_resp} width.
REQ-004 SHALL have parameter QOS_W, default 4, ar_qos width.
REQ-005 SHALL have parameter MAX_OUTST, default 4, maximum outstanding reads, a power of 2 and at least 2.
REQ-006 SHALL have parameter AGE_LIMIT, default 8, number of lost arbitrations before promotion.
REQ-007 SHALL have parameter CONN, default IC_RD_CONNECTIVITY, a NUM_MST-bit mask of connected masters.
REQ-008 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-009 SHALL have port rstn_i, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port cbar_reqst_data_i, input, ADDR_W x NUM_MST, per-master AR address.
REQ-011 SHALL have port cbar_reqst_arqos_i, input, QOS_W x NUM_MST, per-master QoS.
REQ-012 SHALL have ports cbar_reqst_val_i (input) and cbar_reqst_rdy_o (output), NUM_MST bits each, AR handshake per master.
REQ-013 SHALL have ports cbar_resp_val_o (output) and cbar_resp_rdy_i (input), NUM_MST bits each, R handshake per master.
REQ-014 SHALL have port cbar_resp_data_o, output, RDATA_W bits, R payload broadcast to all masters.
REQ-015 SHALL have ports slv_ar_addr_o (ADDR_W), slv_ar_valid_o and slv_ar_ready_i, downstream AR channel.
REQ-016 SHALL have ports slv_r_data_i (RDATA_W), slv_r_valid_i and slv_r_ready_o, downstream R channel.

Function
REQ-017 SHALL treat a master as requesting only when cbar_reqst_val_i[i] & CONN[i]; unconnected slots SHALL drive rdy_o and val_o to 0 at all times.
REQ-018 SHALL, in state IDLE, select the winner combinationally: highest effective QoS; ties broken round-robin, starting at the slot after the last granted master.
REQ-019 SHALL define effective QoS as the maximum value (all ones) when the master's age counter equals AGE_LIMIT, and as its ar_qos otherwise.
REQ-020 SHALL, in IDLE, with at least one request and fewer than MAX_OUTST reads outstanding, register the winner and move to ADDR at the next edge; no AR output is asserted in the IDLE cycle.
REQ-021 SHALL, in ADDR, drive slv_ar_valid_o=1 with the locked winner's address, and SHALL hold the winner and address stable until slv_ar_ready_i.
REQ-022 SHALL, on the ADDR handshake: assert the winner's cbar_reqst_rdy_o in that same cycle; push the winner ID into the ID FIFO; update the round-robin pointer; return to IDLE.
REQ-023 SHALL give AR a minimum cost of 2 cycles per grant, so at most one AR is accepted every 2 cycles.
REQ-024 SHALL keep a per-master age counter: +1 (saturating at AGE_LIMIT) for each granting arbitration the master requested and lost; cleared when that master is granted or drops its valid.
REQ-025 SHALL return R responses in order: slv_r_ready_o = cbar_resp_rdy_i[head]; cbar_resp_val_o = onehot(head) & slv_r_valid_i; cbar_resp_data_o = slv_r_data_i; all are 0/undriven-valid when the FIFO is empty.
REQ-026 SHALL pop the FIFO on the slv_r_valid_i & slv_r_ready_o handshake.
REQ-027 SHALL hold slv_r_ready_o at 0 when the FIFO is empty; slv_r_valid_i in that state is a protocol error and SHALL be ignored.
REQ-028 SHALL, when the FIFO is full, not grant; push and pop in the same cycle SHALL be legal and leave the count unchanged.
REQ-029 SHALL, on a master dropping valid while in ADDR, still complete the AR (the stability rule makes this a master-side error).

Reset
REQ-030 SHALL, on rstn_i low, asynchronously clear state to IDLE, FIFO count/pointers to 0, RR pointer to 0, age counters to 0; all valid/ready outputs SHALL be 0, and data outputs SHALL be 0 where registered.
REQ-031 SHALL, on reset mid-transaction, discard outstanding IDs; no responses are delivered after release.

Structure
REQ-032 SHALL keep IC_NUM_MASTER_SLOTS, IC_ARADDR_WIDTH, IC_RDATA_WIDTH and IC_RD_CONNECTIVITY in liteic_pkg, and SHALL add IC_RD_MAX_OUTST and IC_QOS_AGE_LIMIT there.
REQ-033 SHALL instantiate a sub-module liteic_id_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head); the arbiter SHALL be in-module.

Verification
REQ-034 SHALL cover: masters 0 and 2 requesting with qos 3 and 9 -> master 2 granted first, master 0 second.
REQ-035 SHALL cover: masters 1 and 3 both requesting qos 5, last grant 1 -> 3 granted, then 1.
REQ-036 SHALL cover: master 0 at qos 0 losing 8 times to master 1 at qos 15 -> master 0 granted on the 9th arbitration.
REQ-037 SHALL cover: 4 ARs issued without R (MAX_OUTST=4) -> 5th request stalls; 1 R returned -> 5th AR issued 2 cycles after the pop.
REQ-038 SHALL cover: grants to masters 2, 0, 1, then 3 R beats with resp_rdy toggling -> delivered to 2, 0, 1 in that order, and no beat is lost.
REQ-039 SHALL cover: rstn_i pulsed low with 2 reads outstanding -> all outputs 0 and FIFO empty, and a new read completes normally.

Source files
------------

// File: rtl/liteic_pkg.sv
// Shared LiteIC crossbar parameters and types.
// Slot counts, channel widths and read-node arbitration limits.
package liteic_pkg;

    localparam int IC_NUM_MASTER_SLOTS = 4;
    localparam int IC_ARADDR_WIDTH     = 32;
    localparam int IC_RDATA_WIDTH      = 34;
    localparam int IC_RD_MAX_OUTST     = 4;
    localparam int IC_QOS_AGE_LIMIT    = 8;

    localparam logic [IC_NUM_MASTER_SLOTS-1:0] IC_RD_CONNECTIVITY = '1;

    typedef enum logic {
        RD_IDLE,
        RD_ADDR
    } rd_arb_state_e;

endpackage

// File: rtl/liteic_id_fifo.sv
// In-order ID queue for outstanding reads.
// Push and pop in the same cycle keep the count unchanged.
module liteic_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/liteic_slave_node_rd_arb.sv
// Slave-side read node: QoS/age/round-robin AR arbiter with
// in-order R routing through an outstanding-ID FIFO.
module liteic_slave_node_rd_arb
    import liteic_pkg::*;
#(
    parameter int NUM_MST   = IC_NUM_MASTER_SLOTS,
    parameter int ADDR_W    = IC_ARADDR_WIDTH,
    parameter int RDATA_W   = IC_RDATA_WIDTH,
    parameter int QOS_W     = 4,
    parameter int MAX_OUTST = IC_RD_MAX_OUTST,
    parameter int AGE_LIMIT = IC_QOS_AGE_LIMIT,
    parameter logic [NUM_MST-1:0] CONN = IC_RD_CONNECTIVITY
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_MST-1:0][ADDR_W-1:0]  cbar_reqst_data_i,
    input  logic [NUM_MST-1:0][QOS_W-1:0]   cbar_reqst_arqos_i,
    input  logic [NUM_MST-1:0]              cbar_reqst_val_i,
    output logic [NUM_MST-1:0]              cbar_reqst_rdy_o,
    output logic [NUM_MST-1:0]              cbar_resp_val_o,
    input  logic [NUM_MST-1:0]              cbar_resp_rdy_i,
    output logic [RDATA_W-1:0]              cbar_resp_data_o,
    output logic [ADDR_W-1:0]               slv_ar_addr_o,
    output logic                            slv_ar_valid_o,
    input  logic                            slv_ar_ready_i,
    input  logic [RDATA_W-1:0]              slv_r_data_i,
    input  logic                            slv_r_valid_i,
    output logic                            slv_r_ready_o
);

    localparam int IDW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int AGW = $clog2(AGE_LIMIT + 1);

    rd_arb_state_e    state;
    logic [NUM_MST-1:0] req;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   arb_idx;
    logic [IDW-1:0]   head;
    logic             arb_vld;
    logic [QOS_W-1:0] best;
    logic [AGW-1:0]   age [NUM_MST];
    logic             fifo_full;
    logic             fifo_empty;
    logic             grant;
    logic             ar_hs;
    logic             r_hs;

    assign req   = cbar_reqst_val_i & CONN;
    assign grant = (state == RD_IDLE) & arb_vld & ~fifo_full;
    assign ar_hs = slv_ar_valid_o & slv_ar_ready_i;
    assign r_hs  = slv_r_valid_i & slv_r_ready_o;

    // Scan from the slot after the last grant; strict '>' keeps RR order on ties.
    always_comb begin
        int idx;
        logic [QOS_W-1:0] q;
        idx     = 0;
        q       = '0;
        arb_vld = 1'b0;
        arb_idx = '0;
        best    = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_MST;
            q   = (age[idx] == AGW'(AGE_LIMIT)) ? '1
                                                : cbar_reqst_arqos_i[idx];
            if (req[idx] && (!arb_vld || q > best)) begin
                arb_vld = 1'b1;
                arb_idx = IDW'(idx);
                best    = q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= RD_IDLE;
            win            <= '0;
            rr_ptr         <= '0;
            slv_ar_valid_o <= 1'b0;
            slv_ar_addr_o  <= '0;
        end else begin
            unique case (state)
                RD_IDLE: if (grant) begin
                    state          <= RD_ADDR;
                    win            <= arb_idx;
                    slv_ar_addr_o  <= cbar_reqst_data_i[arb_idx];
                    slv_ar_valid_o <= 1'b1;
                end
                RD_ADDR: if (slv_ar_ready_i) begin
                    state          <= RD_IDLE;
                    slv_ar_valid_o <= 1'b0;
                    rr_ptr         <= win;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_MST; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (!req[i])
                    age[i] <= '0;
                else if (grant && arb_idx == IDW'(i))
                    age[i] <= '0;
                else if (grant && age[i] != AGW'(AGE_LIMIT))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    liteic_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (ar_hs),
        .din    (win),
        .pop    (r_hs),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

    always_comb begin
        cbar_reqst_rdy_o = '0;
        cbar_resp_val_o  = '0;
        cbar_resp_data_o = '0;
        slv_r_ready_o    = 1'b0;
        if (ar_hs) cbar_reqst_rdy_o[win] = 1'b1;
        if (!fifo_empty) begin
            slv_r_ready_o         = cbar_resp_rdy_i[head];
            cbar_resp_val_o[head] = slv_r_valid_i;
            cbar_resp_data_o      = slv_r_data_i;
        end
        cbar_reqst_rdy_o = cbar_reqst_rdy_o & CONN;
        cbar_resp_val_o  = cbar_resp_val_o & CONN;
    end

endmodule

// File: tb/tb_liteic_slave_node_rd_arb.sv
// Directed bench for the LiteIC read arbitration node.
module tb_liteic_slave_node_rd_arb;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [3:0][31:0]  data;
    logic [3:0][3:0]   qos;
    logic [3:0]        val;
    logic [3:0]        rdy;
    logic [3:0]        resp_val;
    logic [3:0]        resp_rdy;
    logic [33:0]       resp_data;
    logic [31:0]       ar_addr;
    logic              ar_valid;
    logic              ar_ready;
    logic [33:0]       r_data;
    logic              r_valid;
    logic              r_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    liteic_slave_node_rd_arb dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cbar_reqst_data_i  (data),
        .cbar_reqst_arqos_i (qos),
        .cbar_reqst_val_i   (val),
        .cbar_reqst_rdy_o   (rdy),
        .cbar_resp_val_o    (resp_val),
        .cbar_resp_rdy_i    (resp_rdy),
        .cbar_resp_data_o   (resp_data),
        .slv_ar_addr_o      (ar_addr),
        .slv_ar_valid_o     (ar_valid),
        .slv_ar_ready_i     (ar_ready),
        .slv_r_data_i       (r_data),
        .slv_r_valid_i      (r_valid),
        .slv_r_ready_o      (r_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    task automatic wait_ar(output int m, output logic [31:0] a);
        bit got = 0;
        m = -1;
        a = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk_i);
            if (ar_valid && ar_ready) begin
                got = 1;
                m   = oh_idx(rdy);
                a   = ar_addr;
            end
        end
        if (got) begin
            @(posedge clk_i); #1;
        end else begin
            chk("ar_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic r_beat(input logic [33:0] d, output int m);
        bit got = 0;
        m = -1;
        r_data  = d;
        r_valid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk_i);
            if (r_valid && r_ready) begin
                got = 1;
                m   = oh_idx(resp_val);
                chk("r_data", resp_data, d);
            end
            @(posedge clk_i); #1;
        end
        r_valid = 1'b0;
        if (!got) chk("r_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int m;
        int k;
        int cnt;
        logic [31:0] a;
        logic [33:0] d [3];

        rstn_i   = 1'b0;
        val      = '0;
        resp_rdy = '0;
        ar_ready = 1'b1;
        r_valid  = 1'b0;
        r_data   = '0;
        for (int i = 0; i < 4; i++) begin
            data[i] = 32'hA000_0000 | (i * 16);
            qos[i]  = '0;
        end

        // reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_ar_addr", ar_addr, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_r_ready", r_ready, 0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;

        // R beat with empty FIFO is ignored
        r_valid  = 1'b1;
        resp_rdy = 4'hF;
        @(negedge clk_i);
        chk("empty_r_ready", r_ready, 0);
        chk("empty_resp_val", resp_val, 0);
        @(posedge clk_i); #1;
        r_valid = 1'b0;

        // qos 3 vs 9: master 2 then 0
        qos[0] = 4'd3;
        qos[2] = 4'd9;
        val    = 4'b0101;
        @(negedge clk_i);
        chk("t1_idle_no_ar", ar_valid, 0);
        wait_ar(m, a);
        chk("t1_first", m, 2);
        chk("t1_first_addr", a, data[2]);
        val[2] = 1'b0;
        wait_ar(m, a);
        chk("t1_second", m, 0);
        chk("t1_second_addr", a, data[0]);
        val[0] = 1'b0;
        r_beat(34'h0_1111_0000, m);
        chk("t1_r0", m, 2);
        r_beat(34'h0_2222_0000, m);
        chk("t1_r1", m, 0);

        // equal qos round robin after last grant 1
        qos = '{default: 4'd5};
        val = 4'b0010;
        wait_ar(m, a);
        chk("t2_pre", m, 1);
        val = 4'b0000;
        r_beat(34'h0_3333_0000, m);
        val = 4'b1010;
        wait_ar(m, a);
        chk("t2_first", m, 3);
        val[3] = 1'b0;
        wait_ar(m, a);
        chk("t2_second", m, 1);
        val[1] = 1'b0;
        r_beat(34'h0_4444_0000, m);
        chk("t2_r0", m, 3);
        r_beat(34'h0_5555_0000, m);
        chk("t2_r1", m, 1);

        // aging: master 0 promoted after 8 losses
        qos[0]   = 4'd0;
        qos[1]   = 4'd15;
        r_data   = 34'h0_6666_0000;
        r_valid  = 1'b1;
        resp_rdy = 4'hF;
        val      = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            wait_ar(m, a);
            chk($sformatf("t3_loss%0d", i), m, 1);
        end
        wait_ar(m, a);
        chk("t3_promoted", m, 0);
        val = '0;
        repeat (4) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("t3_drained", r_ready, 0);
        @(posedge clk_i); #1;
        r_valid = 1'b0;

        // outstanding limit
        qos = '{default: 4'd0};
        val = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            wait_ar(m, a);
            chk($sformatf("t4_ar%0d", i), m, 0);
        end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (ar_valid) cnt++;
        end
        chk("t4_stall", cnt, 0);
        @(posedge clk_i); #1;
        r_data  = 34'h0_7777_0000;
        r_valid = 1'b1;
        @(negedge clk_i);
        chk("t4_pop_rdy", r_ready, 1);
        chk("t4_pop_val", resp_val, 4'b0001);
        @(posedge clk_i); #1;
        r_valid = 1'b0;
        @(negedge clk_i);
        chk("t4_pop_p1", ar_valid, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("t4_pop_p2", ar_valid, 1);
        chk("t4_pop_p2_rdy", rdy, 4'b0001);
        @(posedge clk_i); #1;
        val = '0;
        for (int i = 0; i < 4; i++) begin
            r_beat(34'h0_8888_0000 | 34'(i), m);
            chk($sformatf("t4_r%0d", i), m, 0);
        end

        // in-order delivery with toggling resp_rdy
        val = 4'b0100;
        wait_ar(m, a);
        chk("t5_g0", m, 2);
        val = 4'b0001;
        wait_ar(m, a);
        chk("t5_g1", m, 0);
        val = 4'b0010;
        wait_ar(m, a);
        chk("t5_g2", m, 1);
        val = '0;
        d[0] = {32'hD000_0000, 2'b00};
        d[1] = {32'hD000_0001, 2'b01};
        d[2] = {32'hD000_0002, 2'b10};
        k = 0;
        for (int c = 0; c < 30 && k < 3; c++) begin
            resp_rdy = c[0] ? 4'hF : 4'h0;
            r_data   = d[k];
            r_valid  = 1'b1;
            @(negedge clk_i);
            if (resp_rdy == 4'h0) begin
                chk($sformatf("t5_hold%0d", c), r_ready, 0);
            end else if (r_ready) begin
                case (k)
                    0: chk("t5_dst0", oh_idx(resp_val), 2);
                    1: chk("t5_dst1", oh_idx(resp_val), 0);
                    default: chk("t5_dst2", oh_idx(resp_val), 1);
                endcase
                chk($sformatf("t5_data%0d", k), resp_data, d[k]);
                k++;
            end
            @(posedge clk_i); #1;
        end
        r_valid  = 1'b0;
        resp_rdy = 4'hF;
        chk("t5_count", k, 3);
        @(negedge clk_i);
        chk("t5_empty", r_ready, 0);
        @(posedge clk_i); #1;

        // reset with reads outstanding and AR pending
        val = 4'b0001;
        wait_ar(m, a);
        val = 4'b0010;
        wait_ar(m, a);
        ar_ready = 1'b0;
        val = 4'b0100;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("t6_pending", ar_valid, 1);
        r_valid = 1'b1;
        rstn_i  = 1'b0;
        #1;
        chk("t6_rst_ar_valid", ar_valid, 0);
        chk("t6_rst_addr", ar_addr, 0);
        chk("t6_rst_r_ready", r_ready, 0);
        chk("t6_rst_resp_val", resp_val, 0);
        chk("t6_rst_rdy", rdy, 0);
        val      = '0;
        ar_ready = 1'b1;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("t6_post_r_ready", r_ready, 0);
        chk("t6_post_resp_val", resp_val, 0);
        @(posedge clk_i); #1;
        r_valid = 1'b0;
        val = 4'b1000;
        wait_ar(m, a);
        chk("t6_new_ar", m, 3);
        chk("t6_new_addr", a, data[3]);
        val = '0;
        r_beat(34'h0_9999_0003, m);
        chk("t6_new_r", m, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
